irq_claim_controller: RTL and testbench

Target-domain interrupt consumer: takes already-synchronized interrupt lines, latches them as pending, raises one aggregated level interrupt to the core, and serves a claim/complete handshake that hands out the highest-priority source ID and blocks that source until software completes it. Sits directly behind the per-line 2FF interrupt synchronizers, in the core clock domain, in front of the CPU external-interrupt input.

---
 rtl/irq_claim_pkg.sv | 19 +
 rtl/irq_source_slot.sv | 90 +++++++++
 rtl/irq_claim_controller.sv | 86 ++++++++
 tb/tb_irq_claim_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_claim_pkg.sv
// Shared definitions for the interrupt claim controller.
//   irq_state_e : per-source lifecycle state
//   id_width()  : width needed to encode IDs 0..n, where ID 0 means "none"
//   ID_NONE     : the "no source" ID value
package irq_claim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PENDING    = 2'd1,
        ST_IN_SERVICE = 2'd2
    } irq_state_e;

    localparam int ID_NONE = 0;

    function automatic int id_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/irq_source_slot.sv
// One interrupt source: lifecycle FSM, plus (with IRQ_EDGE_MODE_EN) an
// edge-history bit and a one-deep re-pend flag.
// Configuration macro: IRQ_EDGE_MODE_EN. When it is undefined, edge_mode_i is
// ignored and the source is always level-triggered.
// Ports:
//   clock, resetn   core clock, synchronous active-low reset
//   irq_i           synchronized source line
//   edge_mode_i     1 = rising-edge triggered (macro builds only)
//   claim_hit_i     claim handshake for this source's ID this cycle
//   complete_hit_i  complete strobe carrying this source's ID this cycle
//   pending_o       source is PENDING
//
// state         | meaning
// ST_IDLE       | nothing latched, waiting for a trigger
// ST_PENDING    | latched, may be offered to the core
// ST_IN_SERVICE | claimed by software, waiting for complete
module irq_source_slot
    import irq_claim_pkg::*;
(
    input  logic clock,
    input  logic resetn,
    input  logic irq_i,
    input  logic edge_mode_i,
    input  logic claim_hit_i,
    input  logic complete_hit_i,
    output logic pending_o
);

    irq_state_e state_q;
    logic       trigger;
    logic       level_drop;
    logic       repend_now;

`ifdef IRQ_EDGE_MODE_EN
    logic prev_q;
    logic repend_q;
    logic rise;

    assign rise       = irq_i & ~prev_q;
    assign trigger    = edge_mode_i ? rise : irq_i;
    assign level_drop = ~edge_mode_i & ~irq_i;
    // An edge arriving in the same cycle as the complete still re-pends.
    assign repend_now = edge_mode_i ? (repend_q | rise) : irq_i;
`else
    logic unused_edge_mode;

    assign unused_edge_mode = edge_mode_i;
    assign trigger          = irq_i;
    assign level_drop       = ~irq_i;
    assign repend_now       = irq_i;
`endif

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
`ifdef IRQ_EDGE_MODE_EN
            prev_q   <= 1'b0;
            repend_q <= 1'b0;
`endif
        end else begin
`ifdef IRQ_EDGE_MODE_EN
            prev_q <= irq_i;
`endif
            case (state_q)
                ST_IDLE: begin
                    if (trigger) state_q <= ST_PENDING;
                end
                ST_PENDING: begin
                    // A handshake for the frozen offer wins over a dropped line.
                    if (claim_hit_i)     state_q <= ST_IN_SERVICE;
                    else if (level_drop) state_q <= ST_IDLE;
                end
                ST_IN_SERVICE: begin
                    if (complete_hit_i)
                        state_q <= repend_now ? ST_PENDING : ST_IDLE;
`ifdef IRQ_EDGE_MODE_EN
                    if (complete_hit_i)
                        repend_q <= 1'b0;
                    else if (edge_mode_i && rise)
                        repend_q <= 1'b1;
`endif
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pending_o = (state_q == ST_PENDING);

endmodule

// File: rtl/irq_claim_controller.sv
// Target-domain interrupt consumer: latches synchronized interrupt lines,
// drives one aggregated level interrupt and serves a claim/complete handshake
// handing out the highest-priority (lowest index) pending, enabled source.
// Configuration macro: IRQ_EDGE_MODE_EN (per-source edge triggering).
// Ports:
//   clock, resetn        core clock, synchronous active-low reset
//   irq_in[NUM_IRQ]      synchronized lines, bit i = source ID i+1
//   enable[NUM_IRQ]      per-source mask
//   edge_mode[NUM_IRQ]   1 = edge triggered (macro builds only)
//   irq_out              registered OR of pending & enabled sources
//   claim_valid/ready    offer handshake, claim_id = offered ID
//   complete_valid/id    complete strobe and the ID being completed
module irq_claim_controller
    import irq_claim_pkg::*;
#(
    parameter  int NUM_IRQ = 4,
    localparam int ID_W    = id_width(NUM_IRQ)
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] enable,
    input  logic [NUM_IRQ-1:0] edge_mode,
    output logic               irq_out,
    output logic               claim_valid,
    input  logic               claim_ready,
    output logic [ID_W-1:0]    claim_id,
    input  logic               complete_valid,
    input  logic [ID_W-1:0]    complete_id
);

    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic [ID_W-1:0]    winner_id;
    logic               handshake;

    logic               irq_out_q;
    logic               claim_valid_q;
    logic [ID_W-1:0]    claim_id_q;

    assign handshake = claim_valid_q & claim_ready;
    assign eligible  = pending & enable;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_slot
        irq_source_slot u_slot (
            .clock          (clock),
            .resetn         (resetn),
            .irq_i          (irq_in[i]),
            .edge_mode_i    (edge_mode[i]),
            .claim_hit_i    (handshake && (claim_id_q == ID_W'(i + 1))),
            .complete_hit_i (complete_valid && (complete_id == ID_W'(i + 1))),
            .pending_o      (pending[i])
        );
    end

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        winner_id = ID_W'(ID_NONE);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) winner_id = ID_W'(i + 1);
        end
    end

    // claim_id stays frozen while an offer is outstanding; a handshake always
    // leaves one idle cycle before the next offer is evaluated.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            irq_out_q     <= 1'b0;
            claim_valid_q <= 1'b0;
            claim_id_q    <= ID_W'(ID_NONE);
        end else begin
            irq_out_q <= |eligible;
            if (handshake) begin
                claim_valid_q <= 1'b0;
            end else if (!claim_valid_q && (winner_id != ID_W'(ID_NONE))) begin
                claim_valid_q <= 1'b1;
                claim_id_q    <= winner_id;
            end
        end
    end

    assign irq_out     = irq_out_q;
    assign claim_valid = claim_valid_q;
    assign claim_id    = claim_id_q;

endmodule

// File: tb/tb_irq_claim_controller.sv
module tb_irq_claim_controller;

    localparam int NUM = 4;
    localparam int IDW = 3;

    logic           clock = 1'b0;
    logic           r_resetn = 1'b0;
    logic [NUM-1:0] r_irq = '0;
    logic [NUM-1:0] r_en = '0;
    logic [NUM-1:0] r_em = '0;
    logic           r_ready = 1'b0;
    logic           r_cvld = 1'b0;
    logic [IDW-1:0] r_cid = '0;

    logic           irq_out;
    logic           claim_valid;
    logic [IDW-1:0] claim_id;

    int total = 0;
    int bad   = 0;

    // Reference model: each source is a flag set (pending / in service) plus
    // re-pend and last-sample bits; the offer is a valid/ID pair.
    bit m_pend[NUM];
    bit m_svc[NUM];
    bit m_rep[NUM];
    bit m_prev[NUM];
    bit m_irq;
    bit m_cv;
    int m_cid;

    irq_claim_controller #(.NUM_IRQ(NUM)) dut (
        .clock          (clock),
        .resetn         (r_resetn),
        .irq_in         (r_irq),
        .enable         (r_en),
        .edge_mode      (r_em),
        .irq_out        (irq_out),
        .claim_valid    (claim_valid),
        .claim_ready    (r_ready),
        .claim_id       (claim_id),
        .complete_valid (r_cvld),
        .complete_id    (r_cid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int  win;
        bit  any;
        bit  hs;
        bit  edge_src;
        bit  rise;
        if (!r_resetn) begin
            for (int i = 0; i < NUM; i++) begin
                m_pend[i] = 0; m_svc[i] = 0; m_rep[i] = 0; m_prev[i] = 0;
            end
            m_irq = 0; m_cv = 0; m_cid = 0;
            return;
        end
        win = 0;
        any = 0;
        for (int i = 0; i < NUM; i++) begin
            if (m_pend[i] && r_en[i]) begin
                any = 1;
                if (win == 0) win = i + 1;
            end
        end
        hs = m_cv && r_ready;
        for (int i = 0; i < NUM; i++) begin
`ifdef IRQ_EDGE_MODE_EN
            edge_src = r_em[i];
`else
            edge_src = 0;
`endif
            rise = r_irq[i] && !m_prev[i];
            if (m_svc[i]) begin
                if (r_cvld && int'(r_cid) == i + 1) begin
                    m_svc[i]  = 0;
                    m_pend[i] = edge_src ? (m_rep[i] || rise) : r_irq[i];
                    m_rep[i]  = 0;
                end else if (edge_src && rise) begin
                    m_rep[i] = 1;
                end
            end else if (m_pend[i]) begin
                if (hs && m_cid == i + 1) begin
                    m_pend[i] = 0;
                    m_svc[i]  = 1;
                end else if (!edge_src && !r_irq[i]) begin
                    m_pend[i] = 0;
                end
            end else if (edge_src ? rise : r_irq[i]) begin
                m_pend[i] = 1;
            end
            m_prev[i] = r_irq[i];
        end
        m_irq = any;
        if (hs) m_cv = 0;
        else if (!m_cv && any) begin
            m_cv  = 1;
            m_cid = win;
        end
    endtask

    // One clock: DUT and model both consume the current inputs, then compare.
    task automatic tick();
        @(posedge clock);
        #1;
        model_step();
        chk("model_irq_out", int'(irq_out), int'(m_irq));
        chk("model_claim_valid", int'(claim_valid), int'(m_cv));
        chk("model_claim_id", int'(claim_id), m_cid);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic expect_out(input string tag, input int io, input int cv, input int cid);
        chk({tag, "_irq_out"}, int'(irq_out), io);
        chk({tag, "_claim_valid"}, int'(claim_valid), cv);
        if (cv != 0) chk({tag, "_claim_id"}, int'(claim_id), cid);
    endtask

    task automatic handshake();
        r_ready = 1; tick(); r_ready = 0;
    endtask

    task automatic complete(input int id);
        r_cvld = 1; r_cid = IDW'(id); tick(); r_cvld = 0; r_cid = '0;
    endtask

    initial begin
        int svc_list[$];
        // Reset
        r_resetn = 0; ticks(2);
        chk("reset_irq_out", int'(irq_out), 0);
        chk("reset_claim_valid", int'(claim_valid), 0);
        chk("reset_claim_id", int'(claim_id), 0);

        // Level source 3, two-cycle latency
        r_resetn = 1; r_en = 4'hF; r_irq = 4'b0100;
        tick();
        expect_out("lvl_k", 0, 0, 0);
        tick();
        expect_out("lvl_k1", 1, 1, 3);
        handshake();
        chk("lvl_hs_valid", int'(claim_valid), 0);
        tick();
        expect_out("lvl_hs1", 0, 0, 0);
        complete(3);
        chk("lvl_cmp_valid", int'(claim_valid), 0);
        tick();
        expect_out("lvl_reoffer", 1, 1, 3);

        // Priority / freeze: ID 3 offered, source 1 rises
        r_irq = 4'b0101;
        ticks(2);
        chk("freeze_id", int'(claim_id), 3);
        handshake();
        tick();
        expect_out("prio_next", 1, 1, 1);
        handshake();
        r_irq = 4'b0000;
        complete(1);
        complete(3);
        ticks(2);
        expect_out("prio_clear", 0, 0, 0);

        // Invalid completes while source 3 is in service
        r_irq = 4'b0100; ticks(2);
        handshake();
        r_irq = 4'b0000; tick();
        complete(0); complete(7); complete(4);
        tick();
        expect_out("inv_quiet", 0, 0, 0);
        r_irq = 4'b0100; ticks(2);
        expect_out("inv_still_svc", 0, 0, 0);
        complete(3); tick();
        expect_out("inv_then_valid", 1, 1, 3);
        handshake();
        r_irq = 4'b0000; complete(3); ticks(2);

        // Mask
        r_en = 4'h0; r_irq = 4'b0001; ticks(3);
        expect_out("mask_off", 0, 0, 0);
        r_en = 4'hF; tick();
        expect_out("mask_on", 1, 1, 1);

        // Reset during an accepted offer
        r_ready = 1; r_resetn = 0; tick();
        expect_out("rst_hs", 0, 0, 0);
        chk("rst_hs_id", int'(claim_id), 0);
        r_ready = 0; r_resetn = 1; r_irq = 4'b0000; tick();
        r_irq = 4'b0001; ticks(2);
        expect_out("rst_not_svc", 1, 1, 1);
        handshake(); r_irq = 4'b0000; complete(1); ticks(2);

`ifdef IRQ_EDGE_MODE_EN
        // Edge source 2: two pulses while in service -> one re-offer
        r_em = 4'b0010;
        r_irq = 4'b0010; tick(); r_irq = 4'b0000; tick();
        expect_out("edge_offer", 1, 1, 2);
        handshake();
        for (int p = 0; p < 2; p++) begin
            r_irq = 4'b0010; tick(); r_irq = 4'b0000; tick();
        end
        expect_out("edge_in_svc", 0, 0, 0);
        complete(2); tick();
        expect_out("edge_reoffer", 1, 1, 2);
        handshake(); complete(2); ticks(3);
        expect_out("edge_once", 0, 0, 0);
        r_em = 4'b0000;
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            r_resetn = ($urandom_range(0, 299) != 0);
            for (int b = 0; b < NUM; b++)
                if ($urandom_range(0, 7) == 0) r_irq[b] = ~r_irq[b];
            if ($urandom_range(0, 31) == 0) r_en = NUM'($urandom_range(0, 15)) | 4'b1000;
            if ($urandom_range(0, 63) == 0) r_em = NUM'($urandom_range(0, 15));
            r_ready = $urandom_range(0, 1) == 1;
            r_cvld  = $urandom_range(0, 2) == 0;
            svc_list.delete();
            for (int i = 0; i < NUM; i++) if (m_svc[i]) svc_list.push_back(i + 1);
            if (svc_list.size() > 0 && $urandom_range(0, 1) == 1)
                r_cid = IDW'(svc_list[$urandom_range(0, svc_list.size() - 1)]);
            else
                r_cid = IDW'($urandom_range(0, 7));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
